// File: rtl/grant_decoder.sv
// Grant decoder: turns an encoded (index, valid) grant into a registered one-hot
// grant vector, holds it until done or timeout, then inserts a one-cycle dead gap.
module grant_decoder #(
    parameter int unsigned N       = 4,
    parameter int unsigned IDX_W   = $clog2(N),
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] grant_idx,
    input  logic             grant_valid,
    output logic             grant_ready,
    output logic [N-1:0]     gnt,
    input  logic [N-1:0]     done,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             timeout_err,
    output logic             bad_idx
);

    localparam int unsigned IDX_CMP_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [N-1:0]       gnt_d;
    logic [IDX_W-1:0]   owner_d;
    logic               busy_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               timeout_d;
    logic               bad_d;
    logic               idx_ok;
    logic               owner_done;
    logic               at_limit;

    // Index check is widened by one bit so N itself never truncates.
    assign idx_ok      = ({1'b0, grant_idx} < IDX_CMP_W'(N));
    // gnt is one-hot on the owner while granted, so this isolates done[owner].
    assign owner_done  = |(done & gnt);
    assign at_limit    = (hold_cnt == CNT_W'(TIMEOUT - 1));
    assign grant_ready = rst_n && (state == IDLE);

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        owner_d   = owner;
        busy_d    = busy;
        cnt_d     = hold_cnt;
        timeout_d = 1'b0;
        bad_d     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    if (idx_ok) begin
                        state_d = GRANT;
                        owner_d = grant_idx;
                        gnt_d   = N'(1) << grant_idx;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (hold_cnt != CNT_W'(TIMEOUT)) begin
                    cnt_d = hold_cnt + CNT_W'(1);
                end
                // A release by the owner takes precedence over the timeout.
                if (owner_done || at_limit) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = !owner_done;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            bad_idx     <= 1'b0;
        end else begin
            state       <= state_d;
            gnt         <= gnt_d;
            owner       <= owner_d;
            busy        <= busy_d;
            hold_cnt    <= cnt_d;
            timeout_err <= timeout_d;
            bad_idx     <= bad_d;
        end
    end

endmodule

// File: tb/tb_grant_decoder.sv
// Self-checking bench for grant_decoder: a 4-requester instance and a
// 3-requester instance (non-power-of-two, for out-of-range indices).
module tb_grant_decoder;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic [3:0] cnt;
        logic       ckc;
        logic       ready;
        logic       tout;
        logic       bad;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] idx;
        logic [3:0] dn;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-requester instance
    logic       rst_n = 1'b0;
    logic [1:0] grant_idx = 2'd0;
    logic       grant_valid = 1'b0;
    logic       grant_ready;
    logic [3:0] gnt;
    logic [3:0] done = 4'd0;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] hold_cnt;
    logic       timeout_err;
    logic       bad_idx;

    // 3-requester instance
    logic       rst3_n = 1'b0;
    logic [1:0] idx3 = 2'd0;
    logic       valid3 = 1'b0;
    logic       ready3;
    logic [2:0] gnt3;
    logic [2:0] done3 = 3'd0;
    logic [1:0] owner3;
    logic       busy3;
    logic [3:0] cnt3;
    logic       tout3;
    logic       bad3;

    grant_decoder #(.N(4), .TIMEOUT(15)) u4 (
        .clk(clk), .rst_n(rst_n), .grant_idx(grant_idx), .grant_valid(grant_valid),
        .grant_ready(grant_ready), .gnt(gnt), .done(done), .owner(owner), .busy(busy),
        .hold_cnt(hold_cnt), .timeout_err(timeout_err), .bad_idx(bad_idx)
    );

    grant_decoder #(.N(3), .TIMEOUT(15)) u3 (
        .clk(clk), .rst_n(rst3_n), .grant_idx(idx3), .grant_valid(valid3),
        .grant_ready(ready3), .gnt(gnt3), .done(done3), .owner(owner3), .busy(busy3),
        .hold_cnt(cnt3), .timeout_err(tout3), .bad_idx(bad3)
    );

    exp_t sb4[$];
    exp_t sb3[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] o, input logic b,
                                input logic [3:0] c, input logic ck, input logic r,
                                input logic t, input logic bi);
        exp_t e;
        e.gnt = g; e.owner = o; e.busy = b; e.cnt = c; e.ckc = ck;
        e.ready = r; e.tout = t; e.bad = bi;
        return e;
    endfunction

    function automatic vec_t mkv(input logic r, input logic v, input logic [1:0] i,
                                 input logic [3:0] d, input exp_t e);
        vec_t x;
        x.rst = r; x.valid = v; x.idx = i; x.dn = d; x.e = e;
        return x;
    endfunction

    task automatic cmp(input string tag, input string nm, input logic [7:0] act,
                       input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, expected %0h (t=%0t)", tag, nm, act, req, $time);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input logic [3:0] g,
                             input logic [1:0] o, input logic b, input logic [3:0] c,
                             input logic r, input logic t, input logic bi);
        cmp(tag, "gnt",   8'(g),  8'(e.gnt));
        cmp(tag, "owner", 8'(o),  8'(e.owner));
        cmp(tag, "busy",  8'(b),  8'(e.busy));
        if (e.ckc) cmp(tag, "hold_cnt", 8'(c), 8'(e.cnt));
        cmp(tag, "ready", 8'(r),  8'(e.ready));
        cmp(tag, "timeout_err", 8'(t), 8'(e.tout));
        cmp(tag, "bad_idx", 8'(bi), 8'(e.bad));
    endtask

    // One cycle on the 4-requester instance: drive, queue expectation, clock, compare.
    task automatic cyc4(input string tag, input logic r, input logic v, input logic [1:0] i,
                        input logic [3:0] d, input exp_t e);
        exp_t x;
        rst_n = r; grant_valid = v; grant_idx = i; done = d;
        sb4.push_back(e);
        @(posedge clk);
        #1;
        if (sb4.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.queue: got empty, expected entry", tag);
        end else begin
            x = sb4.pop_front();
            check_out(tag, x, gnt, owner, busy, hold_cnt, grant_ready, timeout_err, bad_idx);
        end
    endtask

    task automatic cyc3(input string tag, input logic r, input logic v, input logic [1:0] i,
                        input logic [3:0] d, input exp_t e);
        exp_t x;
        rst3_n = r; valid3 = v; idx3 = i; done3 = d[2:0];
        sb3.push_back(e);
        @(posedge clk);
        #1;
        if (sb3.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.queue: got empty, expected entry", tag);
        end else begin
            x = sb3.pop_front();
            check_out(tag, x, {1'b0, gnt3}, owner3, busy3, cnt3, ready3, tout3, bad3);
        end
    endtask

    vec_t t4[12];
    vec_t t3[11];

    initial begin
        // Reset, idle, basic grant/release on N=4
        t4[0]  = mkv(0, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 0, 0, 0));
        t4[1]  = mkv(0, 1, 2'd2, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 0, 0, 0));
        t4[2]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 0));
        t4[3]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 0));
        t4[4]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 0));
        t4[5]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 0));
        t4[6]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 0));
        t4[7]  = mkv(1, 1, 2'd2, 4'h0, mk(4'h4, 2'd2, 1, 4'd0, 1, 0, 0, 0));
        t4[8]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h4, 2'd2, 1, 4'd1, 1, 0, 0, 0));
        t4[9]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h4, 2'd2, 1, 4'd2, 1, 0, 0, 0));
        t4[10] = mkv(1, 0, 2'd0, 4'h4, mk(4'h0, 2'd2, 0, 4'd0, 0, 0, 0, 0));
        t4[11] = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd2, 0, 4'd0, 0, 1, 0, 0));

        // N=3: out-of-range index, top index, mid-grant reset
        t3[0]  = mkv(0, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 0, 0, 0));
        t3[1]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 0));
        t3[2]  = mkv(1, 1, 2'd3, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 1));
        t3[3]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 0));
        t3[4]  = mkv(1, 1, 2'd2, 4'h0, mk(4'h4, 2'd2, 1, 4'd0, 1, 0, 0, 0));
        t3[5]  = mkv(1, 0, 2'd0, 4'h4, mk(4'h0, 2'd2, 0, 4'd0, 0, 0, 0, 0));
        t3[6]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd2, 0, 4'd0, 0, 1, 0, 0));
        t3[7]  = mkv(1, 1, 2'd0, 4'h0, mk(4'h1, 2'd0, 1, 4'd0, 1, 0, 0, 0));
        t3[8]  = mkv(1, 0, 2'd0, 4'h0, mk(4'h1, 2'd0, 1, 4'd1, 1, 0, 0, 0));
        t3[9]  = mkv(0, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 0, 0, 0));
        t3[10] = mkv(1, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 0));

        @(posedge clk);
        #1;

        for (int k = 0; k < 12; k++)
            cyc4($sformatf("basic[%0d]", k), t4[k].rst, t4[k].valid, t4[k].idx, t4[k].dn, t4[k].e);

        // Wrong releasers ignored, then timeout after 15 granted cycles
        cyc4("tmo_acc", 1, 1, 2'd1, 4'h0, mk(4'h2, 2'd1, 1, 4'd0, 1, 0, 0, 0));
        for (int k = 1; k <= 14; k++) begin
            logic [3:0] d;
            d = (k == 3) ? 4'h1 : (k == 5) ? 4'h8 : 4'h0;
            cyc4($sformatf("tmo_hold[%0d]", k), 1, 0, 2'd0, d,
                 mk(4'h2, 2'd1, 1, 4'(k), 1, 0, 0, 0));
        end
        cyc4("tmo_fire", 1, 0, 2'd0, 4'h0, mk(4'h0, 2'd1, 0, 4'd0, 0, 0, 1, 0));
        cyc4("tmo_gap",  1, 0, 2'd0, 4'h0, mk(4'h0, 2'd1, 0, 4'd0, 0, 1, 0, 0));
        cyc4("tmo_idle", 1, 0, 2'd0, 4'h0, mk(4'h0, 2'd1, 0, 4'd0, 0, 1, 0, 0));

        // done on the timeout edge wins; encoder holds idx 3 valid throughout
        cyc4("col_acc", 1, 1, 2'd3, 4'h0, mk(4'h8, 2'd3, 1, 4'd0, 1, 0, 0, 0));
        for (int k = 1; k <= 14; k++)
            cyc4($sformatf("col_hold[%0d]", k), 1, 1, 2'd3, 4'h0,
                 mk(4'h8, 2'd3, 1, 4'(k), 1, 0, 0, 0));
        cyc4("col_rel",  1, 1, 2'd3, 4'h8, mk(4'h0, 2'd3, 0, 4'd0, 0, 0, 0, 0));
        cyc4("b2b_gap",  1, 1, 2'd3, 4'h0, mk(4'h0, 2'd3, 0, 4'd0, 0, 1, 0, 0));
        cyc4("b2b_acc",  1, 1, 2'd3, 4'h0, mk(4'h8, 2'd3, 1, 4'd0, 1, 0, 0, 0));
        cyc4("b2b_rel",  1, 0, 2'd0, 4'h8, mk(4'h0, 2'd3, 0, 4'd0, 0, 0, 0, 0));
        cyc4("b2b_idle", 1, 0, 2'd0, 4'h0, mk(4'h0, 2'd3, 0, 4'd0, 0, 1, 0, 0));

        // Reset mid-grant on N=4
        cyc4("rst_acc",  1, 1, 2'd1, 4'h0, mk(4'h2, 2'd1, 1, 4'd0, 1, 0, 0, 0));
        cyc4("rst_mid",  0, 0, 2'd0, 4'h2, mk(4'h0, 2'd0, 0, 4'd0, 1, 0, 0, 0));
        cyc4("rst_rel",  1, 0, 2'd0, 4'h0, mk(4'h0, 2'd0, 0, 4'd0, 1, 1, 0, 0));

        for (int k = 0; k < 11; k++)
            cyc3($sformatf("n3[%0d]", k), t3[k].rst, t3[k].valid, t3[k].idx, t3[k].dn, t3[k].e);

        if (sb4.size() != 0 || sb3.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: got %0d left, expected 0", sb4.size() + sb3.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
